// File: rtl/hpis_reg_bank.sv
// hpis_reg_bank: CPU-bus register bank (version, scratch, ctrl/soft-reset, W1C irq, error capture); optional HPIS_ACC_CNT_EN adds WR_CNT/RD_CNT.
// Latency: writes visible next cycle; read data registered 1 cycle after cpu_rd, held until next cpu_rd.
// Backpressure: none; every cpu_wr/cpu_rd pulse is serviced in its own cycle.
module hpis_reg_bank #(
    parameter int                    ADDR_WIDTH    = 21,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    DATA_BYTE_NUM = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 21'h000000,
    parameter logic [31:0]           VERSION       = 32'h2017_0001,
    parameter int                    IRQ_NUM       = 8,
    parameter int                    SRST_WIDTH    = 16,
    parameter logic [31:0]           UNMAP_DATA    = 32'hDEAD_BEEF
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cpu_wr,
    input  logic [ADDR_WIDTH-1:0]    cpu_wr_addr,
    input  logic [DATA_BYTE_NUM-1:0] cpu_wr_strb,
    input  logic [DATA_WIDTH-1:0]    cpu_data_in,
    input  logic                     cpu_rd,
    output logic [DATA_WIDTH-1:0]    cpu_data_out,
    input  logic [IRQ_NUM-1:0]       irq_src,
    output logic                     irq_out,
    output logic                     soft_rst,
    output logic [7:0]               ctrl_mode
);

    localparam logic [5:0] OFF_VERSION = 6'h00;
    localparam logic [5:0] OFF_SCRATCH = 6'h01;
    localparam logic [5:0] OFF_CTRL    = 6'h02;
    localparam logic [5:0] OFF_STATUS  = 6'h03;
    localparam logic [5:0] OFF_MASK    = 6'h04;
    localparam logic [5:0] OFF_ERRADDR = 6'h05;
    localparam logic [5:0] OFF_ERRCNT  = 6'h06;
    localparam logic [5:0] OFF_WRCNT   = 6'h07;
    localparam logic [5:0] OFF_RDCNT   = 6'h08;

    logic [DATA_WIDTH-1:0] scratch;
    logic [IRQ_NUM-1:0]    int_status;
    logic [IRQ_NUM-1:0]    int_mask;
    logic [ADDR_WIDTH-1:0] err_addr;
    logic [15:0]           err_cnt;
    logic [7:0]            srst_cnt;

    logic                  hit;
    logic [5:0]            offset;
    logic                  mapped;
    logic                  wr_hit;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] wdata_m;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [IRQ_NUM-1:0]    w1c;
    logic [1:0]            err_inc;
    logic [16:0]           err_sum;

    assign hit     = cpu_wr_addr[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8];
    assign offset  = cpu_wr_addr[7:2];
    assign wr_hit  = cpu_wr & hit;
    assign rd_hit  = cpu_rd & hit;
    assign wdata_m = cpu_data_in & wmask;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_BYTE_NUM; b++)
            wmask[b*8 +: 8] = {8{cpu_wr_strb[b]}};
    end

    always_comb begin
        mapped = 1'b0;
        case (offset)
            OFF_VERSION, OFF_SCRATCH, OFF_CTRL, OFF_STATUS,
            OFF_MASK, OFF_ERRADDR, OFF_ERRCNT: mapped = 1'b1;
`ifdef HPIS_ACC_CNT_EN
            OFF_WRCNT, OFF_RDCNT:             mapped = 1'b1;
`endif
            default:                          mapped = 1'b0;
        endcase
    end

`ifdef HPIS_ACC_CNT_EN
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_hit && offset == OFF_WRCNT && |cpu_wr_strb)
                wr_cnt <= '0;
            else if (wr_hit && mapped)
                wr_cnt <= wr_cnt + 32'd1;
            if (wr_hit && offset == OFF_RDCNT && |cpu_wr_strb)
                rd_cnt <= '0;
            else if (rd_hit && mapped)
                rd_cnt <= rd_cnt + 32'd1;
        end
    end
`endif

    // Read mux sees register values from before this cycle's write.
    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_VERSION: rd_data = VERSION;
            OFF_SCRATCH: rd_data = scratch;
            OFF_CTRL:    rd_data[15:8] = ctrl_mode;
            OFF_STATUS:  rd_data[IRQ_NUM-1:0] = int_status;
            OFF_MASK:    rd_data[IRQ_NUM-1:0] = int_mask;
            OFF_ERRADDR: rd_data[ADDR_WIDTH-1:0] = err_addr;
            OFF_ERRCNT:  rd_data[15:0] = err_cnt;
`ifdef HPIS_ACC_CNT_EN
            OFF_WRCNT:   rd_data = wr_cnt;
            OFF_RDCNT:   rd_data = rd_cnt;
`endif
            default:     rd_data = UNMAP_DATA;
        endcase
    end

    assign w1c     = (wr_hit && offset == OFF_STATUS) ? wdata_m[IRQ_NUM-1:0] : '0;
    assign err_inc = {1'b0, wr_hit & ~mapped} + {1'b0, rd_hit & ~mapped};
    assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cpu_data_out <= '0;
            irq_out      <= 1'b0;
            ctrl_mode    <= '0;
            scratch      <= '0;
            int_status   <= '0;
            int_mask     <= '1;
            err_addr     <= '0;
            err_cnt      <= '0;
            srst_cnt     <= '0;
        end else begin
            if (cpu_rd)
                cpu_data_out <= hit ? rd_data : '0;

            if (wr_hit && offset == OFF_SCRATCH)
                scratch <= (scratch & ~wmask) | wdata_m;
            if (wr_hit && offset == OFF_CTRL && cpu_wr_strb[1])
                ctrl_mode <= cpu_data_in[15:8];
            if (wr_hit && offset == OFF_MASK)
                int_mask <= (int_mask & ~wmask[IRQ_NUM-1:0]) | wdata_m[IRQ_NUM-1:0];

            // New source activity wins over a same-cycle W1C clear.
            int_status <= (int_status & ~w1c) | irq_src;
            irq_out    <= |(int_status & ~int_mask);

            if (err_inc != 2'd0)
                err_addr <= cpu_wr_addr;
            if (wr_hit && offset == OFF_ERRCNT && cpu_wr_strb[0])
                err_cnt <= '0;
            else if (err_inc != 2'd0)
                err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];

            if (wr_hit && offset == OFF_CTRL && cpu_wr_strb[0] && cpu_data_in[0])
                srst_cnt <= 8'(SRST_WIDTH);
            else if (srst_cnt != 8'd0)
                srst_cnt <= srst_cnt - 8'd1;
        end
    end

    assign soft_rst = srst_cnt != 8'd0;

endmodule
